// File: rtl/pcie_flow_pkg.sv
// Shared types for the PCIE VC flow controller: state encodings and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcie_flow_pkg;

    localparam int STATE_W    = 3;
    localparam int NUM_VC_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // IDLE and ACTIVE are the only states where traffic flows and errors are detected.
    function automatic logic in_service(state_e s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/pcie_flow_ctrl_if.sv
// Bundle between the flow controller, the FIFO bank and the host/test side.
// Latency: wires only.
// Backpressure: carries sink_ready/push_allow; no buffering here.
interface pcie_flow_ctrl_if
    import pcie_flow_pkg::*;
#(
    parameter int UMBRAL_W = 8,
    parameter int NUM_VC   = NUM_VC_DEF,
    parameter int CNT_W    = 16
);
    logic                       init;
    logic [UMBRAL_W-1:0]        umbral_L_in;
    logic [UMBRAL_W-1:0]        umbral_H_in;
    logic                       push_in;
    logic [NUM_VC-1:0]          fifo_full;
    logic [NUM_VC-1:0]          fifo_empty;
    logic [NUM_VC*UMBRAL_W-1:0] fifo_count;
    logic [NUM_VC-1:0]          sink_ready;
    logic                       req;
    logic [2:0]                 idx;

    logic [NUM_VC-1:0]          pop;
    logic                       push_allow;
    logic [UMBRAL_W-1:0]        umbral_L;
    logic [UMBRAL_W-1:0]        umbral_H;
    logic [STATE_W-1:0]         state;
    logic                       active_out;
    logic                       idle_out;
    logic                       error_out;
    logic [CNT_W-1:0]           count_out;
    logic                       count_valid;

    modport master (
        output init, umbral_L_in, umbral_H_in, push_in, fifo_full, fifo_empty,
               fifo_count, sink_ready, req, idx,
        input  pop, push_allow, umbral_L, umbral_H, state, active_out, idle_out,
               error_out, count_out, count_valid
    );

    modport slave (
        input  init, umbral_L_in, umbral_H_in, push_in, fifo_full, fifo_empty,
               fifo_count, sink_ready, req, idx,
        output pop, push_allow, umbral_L, umbral_H, state, active_out, idle_out,
               error_out, count_out, count_valid
    );

endinterface

// File: rtl/pcie_flow_ctrl_rr_arbiter.sv
// Round-robin grant over N requesters, searching from a rotating pointer.
// Latency: grant is combinational; pointer advances on the granting edge.
// Backpressure: only eligible (non-empty and sink-ready) channels can win.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] eligible,
    input  logic         enable,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % N);
            if (enable && !found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                ptr_d       = PTR_W'((int'(cand) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pcie_flow_ctrl.sv
// Flow-control FSM for the PCIE VC datapath; optional pop statistics under FLOW_CTRL_STATS_EN.
// Latency: pop is combinational; state, thresholds, push_allow and stats reads are registered.
// Backpressure: pops only to sink_ready channels; push_allow drops at umbral_H, returns at umbral_L.
module pcie_flow_ctrl
    import pcie_flow_pkg::*;
#(
    parameter int UMBRAL_W = 8,
    parameter int NUM_VC   = NUM_VC_DEF,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    pcie_flow_ctrl_if.slave bus
);
    state_e              state_q;
    state_e              state_d;
    logic [UMBRAL_W-1:0] umb_l_q;
    logic [UMBRAL_W-1:0] umb_h_q;
    logic                push_allow_q;
    logic                err_evt;
    logic                any_ge;
    logic                all_le;
    logic [NUM_VC-1:0]   eligible;
    logic [NUM_VC-1:0]   grant;

    assign err_evt  = in_service(state_q) && bus.push_in && (|bus.fifo_full);
    assign eligible = ~bus.fifo_empty & bus.sink_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT: begin
                if (!bus.init) state_d = (umb_l_q >= umb_h_q) ? ST_ERROR : ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (err_evt)                                     state_d = ST_ERROR;
                else if (bus.init)                               state_d = ST_INIT;
                else if (state_q == ST_IDLE && !(&bus.fifo_empty)) state_d = ST_ACTIVE;
                else if (state_q == ST_ACTIVE && (&bus.fifo_empty)) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.init) state_d = ST_INIT;
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // Hysteresis inputs: any channel at/above high, every channel at/below low.
    always_comb begin
        any_ge = 1'b0;
        all_le = 1'b1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (bus.fifo_count[i*UMBRAL_W +: UMBRAL_W] >= umb_h_q) any_ge = 1'b1;
            if (bus.fifo_count[i*UMBRAL_W +: UMBRAL_W] >  umb_l_q) all_le = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RESET;
            umb_l_q      <= '0;
            umb_h_q      <= '0;
            push_allow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.init && state_d == ST_INIT) begin
                umb_l_q <= bus.umbral_L_in;
                umb_h_q <= bus.umbral_H_in;
            end
            if (!in_service(state_d)) push_allow_q <= 1'b0;
            else if (any_ge)          push_allow_q <= 1'b0;
            else if (all_le)          push_allow_q <= 1'b1;
        end
    end

    rr_arbiter #(.N(NUM_VC)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .enable   (state_q == ST_ACTIVE),
        .grant    (grant)
    );

`ifdef FLOW_CTRL_STATS_EN
    logic [CNT_W-1:0] pop_cnt_q [NUM_VC];
    logic [CNT_W-1:0] rd_dat;
    logic [CNT_W-1:0] count_out_q;
    logic             count_valid_q;

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (int'(bus.idx) == i) rd_dat = pop_cnt_q[i];
        end
    end

    // Counters restart whenever the block is (re)initialized; clear wins over a same-edge pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VC; i++) pop_cnt_q[i] <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (state_d == ST_INIT)                     pop_cnt_q[i] <= '0;
                else if (grant[i] && pop_cnt_q[i] != '1)    pop_cnt_q[i] <= pop_cnt_q[i] + CNT_W'(1);
            end
            count_valid_q <= bus.req;
            count_out_q   <= bus.req ? rd_dat : '0;
        end
    end

    assign bus.count_out   = count_out_q;
    assign bus.count_valid = count_valid_q;
`else
    logic unused_stats;
    assign unused_stats    = ^{bus.req, bus.idx};
    assign bus.count_out   = '0;
    assign bus.count_valid = 1'b0;
`endif

    assign bus.pop        = grant;
    assign bus.push_allow = push_allow_q;
    assign bus.umbral_L   = umb_l_q;
    assign bus.umbral_H   = umb_h_q;
    assign bus.state      = state_q;
    assign bus.active_out = (state_q == ST_ACTIVE);
    assign bus.idle_out   = (state_q == ST_IDLE);
    assign bus.error_out  = (state_q == ST_ERROR);

endmodule

// File: doc/pcie_flow_ctrl.md
# pcie_flow_ctrl

Main flow-control state machine for the PCIE virtual-channel datapath. Latches the low/high FIFO thresholds during initialization and tracks the RESET/INIT/IDLE/ACTIVE/ERROR state. Gates the upstream push with threshold hysteresis and round-robin arbitrates pops from the four output FIFOs toward ready sinks. It sits between the FIFO bank (flags/counts in, push/pop out) and the test/host side (init, thresholds, req/idx).

## Interface
- UMBRAL_W, 8, width of thresholds and of each FIFO occupancy count
- NUM_VC, 4, number of output FIFOs/channels (design and verification target is 4)
- CNT_W, 16, width of per-channel pop counters (statistics feature)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- init  in  1  request (re)initialization; thresholds sampled while high
- umbral_L_in / umbral_H_in  in  UMBRAL_W each  low/high threshold inputs
- push_in  in  1  upstream push attempt
- fifo_full  in  NUM_VC  per-FIFO full flags
- fifo_empty  in  NUM_VC  per-FIFO empty flags
- fifo_count  in  NUM_VC*UMBRAL_W  occupancy, channel i at bits [i*UMBRAL_W +: UMBRAL_W]
- sink_ready  in  NUM_VC  downstream ready per channel
- req  in  1  statistics read request
- idx  in  3  statistics channel select
- pop  out  NUM_VC  one-hot-or-zero pop strobe
- push_allow  out  1  upstream may push
- umbral_L / umbral_H  out  UMBRAL_W each  latched thresholds
- state  out  3  current state encoding
- active_out / idle_out / error_out  out  1 each  state decodes
- count_out  out  CNT_W  statistics read data
- count_valid  out  1  count_out valid

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; other codes unreachable, decode to RESET.
- RESET -> INIT unconditionally on the first edge after reset deasserts.
- INIT: umbral_L/umbral_H <= inputs every cycle init=1. On init=0: ERROR if latched umbral_L >= umbral_H, else IDLE.
- IDLE: -> ACTIVE if any fifo_empty bit is 0.
- ACTIVE: -> IDLE when all fifo_empty bits are 1.
- Error event: push_in=1 while any fifo_full=1, in IDLE or ACTIVE -> ERROR.
- ERROR: sticky; leaves only via init=1 -> INIT (or reset).
- Priority in IDLE/ACTIVE: error event > init=1 (-> INIT) > empty/non-empty transition.
- Pop arbitration, ACTIVE only: eligible[i] = ~fifo_empty[i] & sink_ready[i].
  - Grant the first eligible channel at or after rr pointer ptr; pop = that one-hot.
  - On grant, ptr <= granted+1 mod NUM_VC. No grant leaves ptr unchanged.
  - pop = 0 in all other states.
- push_allow, registered with hysteresis:
  - clears when any count >= umbral_H;
  - sets when all counts <= umbral_L;
  - otherwise holds.
  - Forced 0 in RESET, INIT and ERROR. On INIT -> IDLE it is evaluated normally; all counts <= umbral_L gives 1.
- active_out = (state==ACTIVE); idle_out = (state==IDLE); error_out = (state==ERROR).

## Timing
- Reset values: state=RESET, all outputs 0, thresholds 0, ptr=0, counters 0.
- State, thresholds, ptr, push_allow and count_out/count_valid are registered. pop is combinational from registered state/ptr and current flags (0-cycle latency).
- Error event sampled at edge N: error_out=1 after edge N. pop is 0 in that same cycle only if state already left ACTIVE.
- init=1 seen at edge N: state=INIT after N; thresholds equal the inputs sampled at the last edge with init=1.
- req seen at edge N: count_out/count_valid valid after N for one cycle; count_valid=0 otherwise.
- Reset mid-operation: everything returns to reset values asynchronously; counters are cleared.

## Configuration
- FLOW_CTRL_STATS_EN defined:
  - one CNT_W pop counter per channel, incremented on each pop, saturating at all-ones;
  - req returns counter[idx] for idx < NUM_VC, 0 for idx >= NUM_VC;
  - counters clear on reset and on entry to INIT.
- Not defined: no counters; count_out=0, count_valid=0; ports remain present.

## Structure
- Package pcie_flow_pkg: state enum/encodings (RESET..ERROR), NUM_VC default, state width constant.
- Sub-module rr_arbiter holds the NUM_VC-wide round-robin grant and pointer. Inputs: eligible, enable. Output: one-hot grant.

## Test plan
- Reset, then init=1 with L=1, H=6 for 3 cycles, then init=0 -> state INIT then IDLE, umbral_L=1, umbral_H=6, push_allow=1.
- init with L=6, H=6 -> ERROR on init fall; init pulse -> INIT; valid L=1, H=6 -> IDLE.
- All four FIFOs non-empty, all sink_ready=1 -> ACTIVE; pops 0001, 0010, 0100, 1000, 0001 on consecutive cycles. sink_ready[1]=0 -> channel 1 skipped.
- Channel 2 count rises to 6 -> push_allow 0 next edge; stays 0 at count 2; returns 1 when all counts <= 1.
- push_in=1 with fifo_full[3]=1 while in ACTIVE -> error_out=1 next edge, pop=0000 thereafter, push_allow=0.
- With FLOW_CTRL_STATS_EN: 5 pops on channel 0, req with idx=0 -> count_out=5, count_valid=1 for one cycle; idx=5 -> 0.
